// File: rtl/watch_pkg.sv
// ============================================================================
// Module      : watch_pkg
// Description : Shared field limits, widths and increment helper for the watch
//               time datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package watch_pkg;

    localparam int MSEC_MAX = 99;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    localparam int MSEC_W = 7;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam int DEF_CLK_FREQ_HZ = 100_000_000;
    localparam int DEF_TICK_HZ     = 100;

    typedef enum logic [1:0] {
        REQ_SEC  = 2'd0,
        REQ_MIN  = 2'd1,
        REQ_HOUR = 2'd2
    } req_e;

    // Adds up to two unit increments and wraps at maxv; sum never exceeds maxv+2.
    function automatic logic [6:0] field_next(input logic [6:0] old_v,
                                              input logic       nat,
                                              input logic       man,
                                              input logic [6:0] maxv);
        logic [7:0] s;
        s = {1'b0, old_v} + {7'd0, nat} + {7'd0, man};
        if (s > {1'b0, maxv}) begin
            s = s - ({1'b0, maxv} + 8'd1);
        end
        return s[6:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/watch_tick_gen.sv
// ============================================================================
// Module      : watch_tick_gen
// Description : Clock divider producing a registered one-cycle tick every DIV
//               clock cycles, first tick DIV cycles after reset release.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module watch_tick_gen
    import watch_pkg::*;
#(
    parameter int DIV = DEF_CLK_FREQ_HZ / DEF_TICK_HZ
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam int              CW     = $clog2(DIV);
    localparam logic [CW-1:0]   c_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic          tick_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= (cnt_q == c_LAST);
            if (cnt_q == c_LAST) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign o_tick = tick_q;

endmodule

`default_nettype wire

// File: rtl/watch_time_dp.sv
// ============================================================================
// Module      : watch_time_dp
// Description : Centisecond/second/minute/hour counter chain with per-field
//               manual increment on request rising edges.
//               Optional auto-repeat on held requests: WATCH_AUTOREPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module watch_time_dp
    import watch_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = DEF_CLK_FREQ_HZ,
    parameter int TICK_HZ      = DEF_TICK_HZ,
    parameter int INIT_HOUR    = 12,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_sec_plus,
    input  logic                i_min_plus,
    input  logic                i_hour_plus,
    output logic [MSEC_W-1:0]   o_msec,
    output logic [SEC_W-1:0]    o_sec,
    output logic [MIN_W-1:0]    o_min,
    output logic [HOUR_W-1:0]   o_hour,
    output logic                o_tick
);

    localparam logic [HOUR_W-1:0] c_INIT_HOUR = 5'(INIT_HOUR);

    if (CLK_FREQ_HZ / TICK_HZ < 2 || INIT_HOUR < 0 || INIT_HOUR > HOUR_MAX ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
        $error("watch_time_dp: invalid parameter configuration");
    end

    logic tick;

    watch_tick_gen #(
        .DIV (CLK_FREQ_HZ / TICK_HZ)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .o_tick (tick)
    );

    logic [2:0] req;
    logic [2:0] prev_q;
    logic [2:0] rise;
    logic [2:0] man;

    assign req  = {i_hour_plus, i_min_plus, i_sec_plus};
    assign rise = req & ~prev_q;

`ifdef WATCH_AUTOREPEAT_EN
    localparam logic [15:0] c_DELAY = 16'(REPEAT_DELAY);
    localparam logic [15:0] c_RATE  = 16'(REPEAT_RATE);

    logic [2:0] rep;

    // hold_q saturates at c_DELAY; rate_q then paces the repeat stream.
    for (genvar g = 0; g < 3; g++) begin : g_repeat
        logic [15:0] hold_q;
        logic [15:0] rate_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hold_q <= '0;
                rate_q <= '0;
            end else if (!req[g] || rise[g]) begin
                hold_q <= '0;
                rate_q <= '0;
            end else if (tick) begin
                if (hold_q < c_DELAY) begin
                    hold_q <= hold_q + 16'd1;
                end else if (rate_q == c_RATE - 16'd1) begin
                    rate_q <= '0;
                end else begin
                    rate_q <= rate_q + 16'd1;
                end
            end
        end

        assign rep[g] = tick && req[g] && !rise[g] &&
                        ((hold_q == c_DELAY - 16'd1) ||
                         (hold_q == c_DELAY && rate_q == c_RATE - 16'd1));
    end

    assign man = rise | rep;
`else
    assign man = rise;
`endif

    logic [MSEC_W-1:0] msec_q, msec_d;
    logic [SEC_W-1:0]  sec_q,  sec_d;
    logic [MIN_W-1:0]  min_q,  min_d;
    logic [HOUR_W-1:0] hour_q, hour_d;
    logic              nat_s, nat_m, nat_h;

    // Carries come only from the natural chain; manual increments never ripple.
    assign nat_s = tick  && (msec_q == 7'(MSEC_MAX));
    assign nat_m = nat_s && (sec_q  == 6'(SEC_MAX));
    assign nat_h = nat_m && (min_q  == 6'(MIN_MAX));

    assign msec_d = field_next(msec_q, tick, 1'b0, 7'(MSEC_MAX));
    assign sec_d  = 6'(field_next({1'b0, sec_q},  nat_s, man[REQ_SEC],  7'(SEC_MAX)));
    assign min_d  = 6'(field_next({1'b0, min_q},  nat_m, man[REQ_MIN],  7'(MIN_MAX)));
    assign hour_d = 5'(field_next({2'b0, hour_q}, nat_h, man[REQ_HOUR], 7'(HOUR_MAX)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
            msec_q <= '0;
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= c_INIT_HOUR;
        end else begin
            prev_q <= req;
            msec_q <= msec_d;
            sec_q  <= sec_d;
            min_q  <= min_d;
            hour_q <= hour_d;
        end
    end

    assign o_msec = msec_q;
    assign o_sec  = sec_q;
    assign o_min  = min_q;
    assign o_hour = hour_q;
    assign o_tick = tick;

endmodule

`default_nettype wire

// File: tb/tb_watch_time_dp.sv
// ============================================================================
// Module      : tb_watch_time_dp
// Description : Self-checking bench for watch_time_dp (tick every 10 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_watch_time_dp;

    localparam int DIV = 10;
    localparam int RD  = 5;
    localparam int RR  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_in = 1'b0, m_in = 1'b0, h_in = 1'b0;
    logic [6:0] o_msec;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic       o_tick;

    watch_time_dp #(
        .CLK_FREQ_HZ  (1000),
        .TICK_HZ      (100),
        .INIT_HOUR    (12),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_sec_plus  (s_in),
        .i_min_plus  (m_in),
        .i_hour_plus (h_in),
        .o_msec      (o_msec),
        .o_sec       (o_sec),
        .o_min       (o_min),
        .o_hour      (o_hour),
        .o_tick      (o_tick)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: clock count since reset plus field arithmetic.
    int  m_ms, m_s, m_m, m_h, m_n;
    int  hold [3];
    bit  prv  [3];
    bit  tk;
    bit  inp  [3];
    bit  inc  [3];
    bit  cs, cm, ch;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ms = 0; m_s = 0; m_m = 0; m_h = 12; m_n = 0;
            for (int i = 0; i < 3; i++) begin
                prv[i] = 0; hold[i] = 0;
            end
        end else begin
            tk = (m_n > 0) && (m_n % DIV == 0);
            inp[0] = s_in; inp[1] = m_in; inp[2] = h_in;
            for (int i = 0; i < 3; i++) begin
                inc[i] = inp[i] && !prv[i];
`ifdef WATCH_AUTOREPEAT_EN
                if (!inp[i] || inc[i]) hold[i] = 0;
                else if (tk) begin
                    hold[i]++;
                    if (hold[i] >= RD && (hold[i] - RD) % RR == 0) inc[i] = 1;
                end
`endif
                prv[i] = inp[i];
            end
            cs = tk && m_ms == 99;
            cm = cs && m_s == 59;
            ch = cm && m_m == 59;
            m_ms = (m_ms + int'(tk)) % 100;
            m_s  = (m_s + int'(cs) + int'(inc[0])) % 60;
            m_m  = (m_m + int'(cm) + int'(inc[1])) % 60;
            m_h  = (m_h + int'(ch) + int'(inc[2])) % 24;
            m_n++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_tick", int'(o_tick), int'((m_n > 0) && (m_n % DIV == 0)));
            chk("model_msec", int'(o_msec), m_ms);
            chk("model_sec",  int'(o_sec),  m_s);
            chk("model_min",  int'(o_min),  m_m);
            chk("model_hour", int'(o_hour), m_h);
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; s_in = 1'b0; m_in = 1'b0; h_in = 1'b0;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic set_req(input int which, input logic v);
        case (which)
            0:       s_in = v;
            1:       m_in = v;
            default: h_in = v;
        endcase
    endtask

    task automatic pulses(input int which, input int n);
        for (int i = 0; i < n; i++) begin
            set_req(which, 1'b1); cyc(1);
            set_req(which, 1'b0); cyc(1);
        end
    endtask

    // Leaves the bench at a negedge where o_tick=1 and o_msec=99.
    task automatic wait_tick99(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (o_tick && o_msec == 7'd99) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) chk("wait_tick99_timeout", 0, 1);
    endtask

    typedef struct {
        bit rs, rm, rh;
        int hi;
        int es, em, eh;
    } vec_t;

    vec_t tbl [6];
    bit   ok;
    int   base;

    initial begin
        tbl[0] = '{1, 0, 0,  1, 1, 0, 12};
        tbl[1] = '{0, 1, 0,  3, 1, 1, 12};
        tbl[2] = '{0, 0, 1,  1, 1, 1, 13};
        tbl[3] = '{1, 1, 1,  2, 2, 2, 14};
        tbl[4] = '{1, 0, 0, 30, 3, 2, 14};
        tbl[5] = '{0, 0, 1,  1, 3, 2, 15};

        // Reset state
        cyc(1);
        #1;
        chk("reset_msec", int'(o_msec), 0);
        chk("reset_hour", int'(o_hour), 12);
        chk("reset_tick", int'(o_tick), 0);
        do_reset();

        // Table of manual request patterns from a fresh reset
        for (int i = 0; i < 6; i++) begin
            s_in = tbl[i].rs; m_in = tbl[i].rm; h_in = tbl[i].rh;
            cyc(tbl[i].hi);
            s_in = 1'b0; m_in = 1'b0; h_in = 1'b0;
            cyc(1);
            chk($sformatf("tbl%0d_sec", i),  int'(o_sec),  tbl[i].es);
            chk($sformatf("tbl%0d_min", i),  int'(o_min),  tbl[i].em);
            chk($sformatf("tbl%0d_hour", i), int'(o_hour), tbl[i].eh);
        end

        // 6000 ticks of free running
        do_reset();
        cyc(60001);
        chk("run_msec", int'(o_msec), 0);
        chk("run_sec",  int'(o_sec),  0);
        chk("run_min",  int'(o_min),  1);
        chk("run_hour", int'(o_hour), 12);

        // Preload 23:59:59 and roll over through 99 cs
        do_reset();
        pulses(2, 11);
        pulses(1, 59);
        pulses(0, 59);
        wait_tick99(ok);
        chk("pre_hms", int'(o_hour) * 10000 + int'(o_min) * 100 + int'(o_sec), 235959);
        cyc(1);
        chk("roll_msec", int'(o_msec), 0);
        chk("roll_sec",  int'(o_sec),  0);
        chk("roll_min",  int'(o_min),  0);
        chk("roll_hour", int'(o_hour), 0);

`ifndef WATCH_AUTOREPEAT_EN
        // Held level gives a single increment
        do_reset();
        cyc(3);
        s_in = 1'b1;
        cyc(1);
        chk("hold_first", int'(o_sec), 1);
        cyc(499);
        chk("hold_end", int'(o_sec), 1);
        s_in = 1'b0;
        cyc(2);
        s_in = 1'b1;
        cyc(1);
        chk("hold_reassert", int'(o_sec), 2);
        s_in = 1'b0;
`else
        // Auto-repeat: edge plus repeats at held ticks 5, 7, 9, 11
        do_reset();
        cyc(3);
        m_in = 1'b1;
        cyc(1);
        chk("rep_edge", int'(o_min), 1);
        cyc(110);
        chk("rep_total", int'(o_min), 5);
        m_in = 1'b0;
`endif

        // sec=59, manual edge on the 99 cs tick
        do_reset();
        pulses(0, 59);
        wait_tick99(ok);
        s_in = 1'b1;
        cyc(1);
        s_in = 1'b0;
        chk("both_sec",  int'(o_sec),  1);
        chk("both_min",  int'(o_min),  1);
        chk("both_msec", int'(o_msec), 0);

        // sec=59 manual wrap without carry
        do_reset();
        pulses(0, 60);
        chk("wrap_sec", int'(o_sec), 0);
        chk("wrap_min", int'(o_min), 0);

        // Asynchronous reset with hour request held
        cyc(37);
        h_in = 1'b1;
        cyc(3);
        base = int'(o_hour);
        chk("pre_rst_hour", base, 13);
        #2 rst = 1'b1;
        #1;
        chk("arst_msec", int'(o_msec), 0);
        chk("arst_sec",  int'(o_sec),  0);
        chk("arst_min",  int'(o_min),  0);
        chk("arst_hour", int'(o_hour), 12);
        chk("arst_tick", int'(o_tick), 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1);
        chk("post_rst_hour", int'(o_hour), 13);
        cyc(2);
        chk("post_rst_hold", int'(o_hour), 13);
        h_in = 1'b0;

        // Random request traffic against the model
        for (int i = 0; i < 3000; i++) begin
            s_in = ($urandom_range(0, 3) == 0);
            m_in = ($urandom_range(0, 5) == 0);
            h_in = ($urandom_range(0, 7) == 0);
            cyc(1);
        end
        s_in = 1'b0; m_in = 1'b0; h_in = 1'b0;
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/watch_time_dp.md
Name: watch_time_dp

Overview:
- Time-keeping datapath that consumes the registered sec/min/hour "plus" request levels from the watch control unit.
- Runs a centisecond/second/minute/hour counter chain from a clock-derived tick.
- Applies exactly one increment per asserted plus request to the addressed field.
- Outputs feed the FND/UART display formatter.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- TICK_HZ, 100, centisecond tick rate; tick period = CLK_FREQ_HZ/TICK_HZ cycles (integer, ≥2).
- INIT_HOUR, 12, hour value loaded at reset (0..23).
- REPEAT_DELAY, 50, ticks a request must stay high before auto-repeat starts (feature only).
- REPEAT_RATE, 10, ticks between auto-repeat increments (feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- i_sec_plus  in  1  level request from control unit: add 1 to seconds
- i_min_plus  in  1  level request: add 1 to minutes
- i_hour_plus  in  1  level request: add 1 to hours
- o_msec  out  7  centiseconds 0..99
- o_sec  out  6  seconds 0..59
- o_min  out  6  minutes 0..59
- o_hour  out  5  hours 0..23
- o_tick  out  1  one-cycle pulse on each centisecond tick

Behaviour:
- Reset values (async, immediate): o_msec=0, o_sec=0, o_min=0, o_hour=INIT_HOUR, o_tick=0.
  - Tick divider count=0; request edge registers=0.
- Tick generator:
  - Counter 0..(CLK_FREQ_HZ/TICK_HZ − 1); o_tick=1 for exactly the cycle the counter wraps.
  - First tick occurs CLK_FREQ_HZ/TICK_HZ cycles after reset release.
- Natural chain (all fields registered, updated on the tick cycle):
  - msec increments on tick.
  - sec increments when tick && msec==99.
  - min increments when that sec carry && sec==59.
  - hour increments when that min carry && min==59.
  - Wrap points: 99→0, 59→0, 59→0, 23→0.
- Manual increment:
  - Each request input has its own rising-edge detector (prev register).
  - Edge = input && !prev; prev updates every cycle.
  - An edge adds 1 to its field on the next clock edge: output changes 1 cycle after the input's first high cycle.
  - A held level produces no further increments unless WATCH_AUTOREPEAT_EN is defined.
- Field update rule, per field: new = (old + nat + man) mod N, where nat, man ∈ {0,1}.
  - Carry to the next field comes only from the natural path: nat && old==max.
  - Manual increments never carry.
  - Example: sec=59 manual → sec=0, min unchanged.
- Simultaneous events:
  - Manual and natural increment on the same field in the same cycle → field advances by 2 mod N.
  - Example: sec=59, tick carry + manual edge → sec=1; min still receives the natural carry.
  - Several request edges in one cycle are all applied independently.
- Reset mid-operation: all state returns to reset values immediately.
  - A request still high at reset release is seen as a rising edge (prev=0), giving exactly one increment on the first clock after release.
- Outputs are direct register outputs; no combinational path from inputs to outputs.

Optional Feature:
- Macro: WATCH_AUTOREPEAT_EN.
- Defined:
  - Each request has a hold counter in ticks, cleared on the input's rising edge and whenever the input is low.
  - After the input has been held REPEAT_DELAY ticks, one extra manual increment is issued.
  - Another follows every REPEAT_RATE ticks while the input stays high.
  - Repeat increments obey the same no-carry, mod-N, simultaneous-event rules.
- Undefined: hold counters are not synthesized; strictly one increment per rising edge.

Decomposition:
- Package watch_pkg holds:
  - Field limits: MSEC_MAX=99, SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - Field widths: 7/6/6/5.
  - Default CLK_FREQ_HZ/TICK_HZ.
- One sub-module: watch_tick_gen (parameterised divider producing o_tick).
- Field counters and edge/repeat logic stay in watch_time_dp.

Test Plan (CLK_FREQ_HZ=1000, TICK_HZ=100 → tick every 10 cycles; INIT_HOUR=12):
- Reset release, no requests, run 6000 ticks → o_msec=0, o_sec=0, o_min=1, o_hour=12; o_tick pulses exactly every 10 cycles, width 1.
- Preload to 23:59:59.99 via manual requests, then next tick → 00:00:00.00 in a single cycle.
- i_sec_plus held high for 500 cycles, feature off → o_sec increases by exactly 1, one cycle after assertion; release and reassert → +1 again.
- sec=59, msec=99, i_sec_plus rising edge on the same cycle as the tick → sec=1, min+1, msec=0.
- sec=59, manual i_sec_plus edge with no tick → sec=0, min unchanged.
- With WATCH_AUTOREPEAT_EN, REPEAT_DELAY=5, REPEAT_RATE=2, i_min_plus held 11 ticks → min +1 at edge, then +1 at tick 5, 7, 9, 11 (total +5).
- Also: assert rst mid-count with i_hour_plus held → outputs return to 00:00:00 / hour 12 immediately; after release o_hour=13 one clock later.
